// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes and datapath select codes.
// The JALRADR state is only reachable when RV_JALR_EN is defined.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StJal      = 4'd9,
      StBranch   = 4'd10,
      StLui      = 4'd11,
      StAuipc    = 4'd12,
      StJalrAdr  = 4'd13
   } state_e;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'd0,
      AluOpSub   = 2'd1,
      AluOpFunct = 2'd2
   } aluop_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [1:0] ALUSRCA_PC    = 2'b00;
   localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
   localparam logic [1:0] ALUSRCA_RS1   = 2'b10;
   localparam logic [1:0] ALUSRCA_ZERO  = 2'b11;

   localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
   localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
   localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

   localparam logic [1:0] RESULT_ALUOUT = 2'b00;
   localparam logic [1:0] RESULT_MEM    = 2'b01;
   localparam logic [1:0] RESULT_ALU    = 2'b10;

   function automatic logic [2:0] immsrc_dec(input logic [6:0] op);
      logic [2:0] imm;
      imm = IMM_I;
      case (op)
         OP_LOAD, OP_IALU, OP_JALR: imm = IMM_I;
         OP_STORE:                  imm = IMM_S;
         OP_BRANCH:                 imm = IMM_B;
         OP_JAL:                    imm = IMM_J;
         OP_LUI, OP_AUIPC:          imm = IMM_U;
         default:                   imm = 3'b000;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// Combinational ALU decoder: maps the FSM's aluop request plus funct fields to an ALU control code.
module mc_aludec
   import multicycle_controller_pkg::*;
(
   input  aluop_e     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alucontrol_o
);

   always_comb begin
      alucontrol_o = ALU_ADD;
      unique case (aluop_i)
         AluOpAdd: alucontrol_o = ALU_ADD;
         AluOpSub: alucontrol_o = ALU_SUB;
         AluOpFunct: begin
            case (funct3_i)
               // Only R-type (op[5]=1) can subtract; addi ignores funct7b5
               3'b000:  alucontrol_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alucontrol_o = ALU_SLL;
               3'b010:  alucontrol_o = ALU_SLT;
               3'b100:  alucontrol_o = ALU_XOR;
               3'b101:  alucontrol_o = ALU_SRL;
               3'b110:  alucontrol_o = ALU_OR;
               3'b111:  alucontrol_o = ALU_AND;
               default: alucontrol_o = ALU_ADD;
            endcase
         end
         default: alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle RV32I datapath.
// Define RV_JALR_EN to support jalr through the JALRADR state; otherwise jalr is illegal.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic [2:0] immsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic [1:0] resultsrc,
   output logic       adrsrc,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       illegal_op
);

   state_e state_q, state_d;
   aluop_e aluop;
   logic   ir_we, pc_we, reg_we, mem_we, ill;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = StFetch;
      alusrca   = ALUSRCA_PC;
      alusrcb   = ALUSRCB_RS2;
      aluop     = AluOpAdd;
      resultsrc = RESULT_ALUOUT;
      adrsrc    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      ill       = 1'b0;
      case (state_q)
         StFetch: begin
            alusrcb   = ALUSRCB_FOUR;
            resultsrc = RESULT_ALU;
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            state_d   = StDecode;
         end
         StDecode: begin
            // Precompute branch/jump target into ALUOut
            alusrca = ALUSRCA_OLDPC;
            alusrcb = ALUSRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = StMemAdr;
               OP_RTYPE:          state_d = StExecuteR;
               OP_IALU:           state_d = StExecuteI;
               OP_JAL:            state_d = StJal;
               OP_BRANCH:         state_d = StBranch;
               OP_LUI:            state_d = StLui;
               OP_AUIPC:          state_d = StAuipc;
`ifdef RV_JALR_EN
               OP_JALR: begin
                  if (funct3 == 3'b000) begin
                     state_d = StJalrAdr;
                  end else begin
                     ill = 1'b1;
                  end
               end
`endif
               default:           ill = 1'b1;
            endcase
         end
         StMemAdr: begin
            alusrca = ALUSRCA_RS1;
            alusrcb = ALUSRCB_IMM;
            if (op == OP_LOAD) begin
               state_d = StMemRead;
            end else if (op == OP_STORE) begin
               state_d = StMemWrite;
            end
         end
         StMemRead: begin
            adrsrc  = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            resultsrc = RESULT_MEM;
            reg_we    = 1'b1;
         end
         StMemWrite: begin
            adrsrc = 1'b1;
            mem_we = 1'b1;
         end
         StExecuteR: begin
            alusrca = ALUSRCA_RS1;
            aluop   = AluOpFunct;
            state_d = StAluWb;
         end
         StExecuteI: begin
            alusrca = ALUSRCA_RS1;
            alusrcb = ALUSRCB_IMM;
            aluop   = AluOpFunct;
            state_d = StAluWb;
         end
         StAluWb: reg_we = 1'b1;
         StJal: begin
            // Link value oldPC+4 goes to ALUWB while PC takes the target held in ALUOut
            alusrca = ALUSRCA_OLDPC;
            alusrcb = ALUSRCB_FOUR;
            pc_we   = 1'b1;
            state_d = StAluWb;
         end
         StBranch: begin
            alusrca = ALUSRCA_RS1;
            aluop   = AluOpSub;
            pc_we   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
         end
         StLui: begin
            alusrca = ALUSRCA_ZERO;
            alusrcb = ALUSRCB_IMM;
            state_d = StAluWb;
         end
         StAuipc: begin
            alusrca = ALUSRCA_OLDPC;
            alusrcb = ALUSRCB_IMM;
            state_d = StAluWb;
         end
`ifdef RV_JALR_EN
         StJalrAdr: begin
            alusrca = ALUSRCA_RS1;
            alusrcb = ALUSRCB_IMM;
            state_d = StJal;
         end
`endif
         default: state_d = StFetch;
      endcase
   end

   mc_aludec u_aludec (
      .aluop_i      (aluop),
      .funct3_i     (funct3),
      .funct7b5_i   (funct7b5),
      .op5_i        (op[5]),
      .alucontrol_o (alucontrol)
   );

   assign immsrc = immsrc_dec(op);

   // FETCH is forced during reset, so its enables must be masked explicitly
   assign irwrite    = ir_we & ~reset;
   assign pcwrite    = pc_we & ~reset;
   assign regwrite   = reg_we & ~reset;
   assign memwrite   = mem_we & ~reset;
   assign illegal_op = ill & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors go through a scoreboard.
// Honours RV_JALR_EN the same way as the design.
module tb_multicycle_controller;

   typedef struct packed {
      logic [2:0] imm;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [2:0] aluc;
      logic [1:0] res;
      logic       adr;
      logic       ir;
      logic       pc;
      logic       rw;
      logic       mw;
      logic       ill;
   } exp_t;

   logic       clk, reset, funct7b5, zero;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [2:0] immsrc, alucontrol;
   logic [1:0] alusrca, alusrcb, resultsrc;
   logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal_op;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .immsrc     (immsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .resultsrc  (resultsrc),
      .adrsrc     (adrsrc),
      .irwrite    (irwrite),
      .pcwrite    (pcwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                               input logic [2:0] alu, input logic [1:0] res, input logic adr,
                               input logic ir, input logic pc, input logic rw, input logic mw,
                               input logic ill);
      exp_t e;
      e = '{imm, a, b, alu, res, adr, ir, pc, rw, mw, ill};
      return e;
   endfunction

   // Common per-state vectors; imm is the immsrc expected for the current op
   function automatic exp_t e_fetch(input logic [2:0] imm);
      return mk(imm, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic exp_t e_decode(input logic [2:0] imm, input logic ill);
      return mk(imm, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
   endfunction
   function automatic exp_t e_aluwb(input logic [2:0] imm);
      return mk(imm, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction
   function automatic exp_t e_reset(input logic [2:0] imm);
      return mk(imm, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   // Compare the DUT outputs right now against the oldest scoreboard entry
   task automatic chk(input string tag, input exp_t e);
      exp_t got, want;
      exp_q.push_back(e);
      got  = '{immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
               irwrite, pcwrite, regwrite, memwrite, illegal_op};
      want = exp_q.pop_front();
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   // Check on the falling edge, then step past the next rising edge
   task automatic cyc(input string tag, input exp_t e);
      @(negedge clk);
      chk(tag, e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z);
      op = o;
      funct3 = f3;
      funct7b5 = f7;
      zero = z;
   endtask

   task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic taken);
      set_instr(7'b1100011, f3, 1'b0, z);
      cyc({tag, "_fetch"}, e_fetch(3'b010));
      cyc({tag, "_decode"}, e_decode(3'b010, 1'b0));
      cyc({tag, "_branch"}, mk(3'b010, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, taken,
                               1'b0, 1'b0, 1'b0));
   endtask

   task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] aluc);
      logic [1:0] srcb;
      srcb = (o == 7'b0110011) ? 2'b00 : 2'b01;
      set_instr(o, f3, f7, 1'b0);
      cyc({tag, "_fetch"}, e_fetch(3'b000));
      cyc({tag, "_decode"}, e_decode(3'b000, 1'b0));
      cyc({tag, "_exec"}, mk(3'b000, 2'b10, srcb, aluc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0));
      cyc({tag, "_aluwb"}, e_aluwb(3'b000));
   endtask

   initial begin
      reset = 1'b1;
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("reset_init", e_reset(3'b000));
      reset = 1'b0;

      // lw aborted by reset in MEMADR
      cyc("lwab_fetch", e_fetch(3'b000));
      cyc("lwab_decode", e_decode(3'b000, 1'b0));
      @(negedge clk);
      chk("lwab_memadr", mk(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0));
      reset = 1'b1;
      #1;
      chk("rst_async", e_reset(3'b000));
      @(posedge clk);
      #1;
      chk("rst_held", e_reset(3'b000));
      reset = 1'b0;

      // lw complete
      cyc("lw_fetch", e_fetch(3'b000));
      cyc("lw_decode", e_decode(3'b000, 1'b0));
      cyc("lw_memadr", mk(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0));
      cyc("lw_memread", mk(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0));
      cyc("lw_memwb", mk(3'b000, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                         1'b0));

      // sw
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      cyc("sw_fetch", e_fetch(3'b001));
      cyc("sw_decode", e_decode(3'b001, 1'b0));
      cyc("sw_memadr", mk(3'b001, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0));
      cyc("sw_memwrite", mk(3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0));

      run_branch("beq_t", 3'b000, 1'b1, 1'b1);
      run_branch("beq_n", 3'b000, 1'b0, 1'b0);
      run_branch("bne_t", 3'b001, 1'b0, 1'b1);
      run_branch("bne_n", 3'b001, 1'b1, 1'b0);
      run_branch("blt_n", 3'b100, 1'b1, 1'b0);

      run_alu("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
      run_alu("add", 7'b0110011, 3'b000, 1'b0, 3'b000);
      run_alu("and", 7'b0110011, 3'b111, 1'b0, 3'b010);
      run_alu("sll", 7'b0110011, 3'b001, 1'b0, 3'b110);
      run_alu("slt", 7'b0110011, 3'b010, 1'b0, 3'b101);
      run_alu("sra", 7'b0110011, 3'b101, 1'b1, 3'b111);
      run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
      run_alu("xori", 7'b0010011, 3'b100, 1'b0, 3'b100);
      run_alu("ori", 7'b0010011, 3'b110, 1'b0, 3'b011);
      run_alu("f3_011", 7'b0010011, 3'b011, 1'b0, 3'b000);

      // lui
      set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
      cyc("lui_fetch", e_fetch(3'b100));
      cyc("lui_decode", e_decode(3'b100, 1'b0));
      cyc("lui_lui", mk(3'b100, 2'b11, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0));
      cyc("lui_aluwb", e_aluwb(3'b100));

      // auipc
      set_instr(7'b0010111, 3'b000, 1'b0, 1'b0);
      cyc("auipc_fetch", e_fetch(3'b100));
      cyc("auipc_decode", e_decode(3'b100, 1'b0));
      cyc("auipc_auipc", mk(3'b100, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0));
      cyc("auipc_aluwb", e_aluwb(3'b100));

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      cyc("jal_fetch", e_fetch(3'b011));
      cyc("jal_decode", e_decode(3'b011, 1'b0));
      cyc("jal_jal", mk(3'b011, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                        1'b0));
      cyc("jal_aluwb", e_aluwb(3'b011));

      // jalr
      set_instr(7'b1100111, 3'b000, 1'b0, 1'b0);
      cyc("jalr_fetch", e_fetch(3'b000));
`ifdef RV_JALR_EN
      cyc("jalr_decode", e_decode(3'b000, 1'b0));
      cyc("jalr_adr", mk(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0));
      cyc("jalr_jal", mk(3'b000, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b0));
      cyc("jalr_aluwb", e_aluwb(3'b000));
`else
      cyc("jalr_decode", e_decode(3'b000, 1'b1));
`endif
      cyc("jalr_next", e_fetch(3'b000));

      // Unsupported opcode
      set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
      cyc("ill_decode", e_decode(3'b000, 1'b1));
      cyc("ill_next", e_fetch(3'b000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM controller that sequences the shared multicycle RV32I datapath: one ALU, one memory port, one immediate extender.
- Per state it selects the immediate format (immsrc), the ALU operands and operation, the result mux, and the memory/register/PC/IR write enables.
- Sits beside the datapath in the multicycle core top level. Takes op/funct fields from the instruction register and the ALU zero flag.

Parameters:
- None. Encodings are fixed in the shared package.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- immsrc  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U
- alusrca  out  2  00 PC, 01 oldPC, 10 rs1, 11 constant zero
- alusrcb  out  2  00 rs2, 01 immext, 10 constant 4
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- resultsrc  out  2  00 ALUOut, 01 memory data, 10 ALU result
- adrsrc  out  1  0 PC, 1 result
- irwrite  out  1  load instruction register and oldPC
- pcwrite  out  1  load PC
- regwrite  out  1  register file write
- memwrite  out  1  data memory write
- illegal_op  out  1  high in DECODE for an unsupported opcode

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - Reset forces state to FETCH.
  - While reset is high, irwrite, pcwrite, regwrite, memwrite and illegal_op are 0. Other outputs take their FETCH values.
- State register: 4-bit. Next state is registered on the clk rising edge. All outputs are combinational from state, op, funct3, funct7b5 and zero.
- immsrc is decoded from op in every state:
  - 0000011, 0010011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111, 0010111 -> U
  - anything else -> 000
- States, outputs and transitions (unlisted outputs are 0/00):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=add (branch/jump target into ALUOut). Next by op:
    - lw/sw -> MEMADR
    - R-type -> EXECUTER
    - I-ALU -> EXECUTEI
    - jal -> JAL
    - branch -> BRANCH
    - lui -> LUI
    - auipc -> AUIPC
    - anything else -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: alusrca=10, alusrcb=01, aluop=add. Next: MEMREAD if op=lw, MEMWRITE if op=sw.
  - MEMREAD: resultsrc=00, adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=funct. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=funct. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcwrite=1. Next: ALUWB.
  - BRANCH: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00. Next: FETCH.
    - pcwrite = (funct3=000 & zero) | (funct3=001 & ~zero).
    - Any other funct3 is not taken.
  - LUI: alusrca=11, alusrcb=01, aluop=add. Next: ALUWB.
  - AUIPC: alusrca=01, alusrcb=01, aluop=add. Next: ALUWB.
- ALU decode (aluop=funct), by funct3:
  - 000: sub if op[5] & funct7b5, else add
  - 001: sll
  - 010: slt
  - 100: xor
  - 101: srl
  - 110: or
  - 111: and
  - 011: add
- Latency in cycles: lw 5; sw, R-type, I-ALU, jal, lui, auipc 4; branch 3; illegal 2.
- Unused state encodings go to FETCH on the next edge with all write enables 0.
- Reset asserted mid-instruction aborts it. No write enable is asserted after the reset edge.

Optional Feature:
- Macro: RV_JALR_EN.
- Defined: adds state JALRADR.
  - DECODE with op=1100111 and funct3=000 -> JALRADR.
  - JALRADR: alusrca=10, alusrcb=01, aluop=add (ALUOut = rs1 + imm). Next: JAL.
  - Bit 0 of the target is cleared by the datapath.
- Undefined: op=1100111 is illegal (DECODE -> FETCH, illegal_op=1).

Decomposition:
- Shared package:
  - state encoding constants
  - opcode constants
  - IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  - ALU_* control codes
  - ALUSRCA_*, ALUSRCB_*, RESULT_* select codes
- Sub-module: mc_aludec, a combinational ALU decoder (aluop, funct3, funct7b5, op[5] -> alucontrol).

Test Plan:
- Reset mid-MEMADR of lw: state returns to FETCH; irwrite, pcwrite, regwrite, memwrite all 0 while reset is high. After release: FETCH outputs irwrite=1, pcwrite=1.
- lw (op=0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. immsrc=000 throughout; regwrite=1 only in MEMWB with resultsrc=01.
- sw (op=0100011): immsrc=001; memwrite=1 only in MEMWRITE with adrsrc=1; regwrite never 1.
- beq (funct3=000): zero=1 gives pcwrite=1 in BRANCH, zero=0 gives 0. bne (funct3=001): inverse. funct3=100 gives pcwrite=0. immsrc=010.
- sub (op=0110011, funct3=000, funct7b5=1): alucontrol=001 in EXECUTER. addi with funct7b5=1: alucontrol=000. lui: immsrc=100, alusrca=11.
- op=1100111 without RV_JALR_EN: illegal_op=1 in DECODE, next FETCH. With RV_JALR_EN: sequence DECODE, JALRADR, JAL, ALUWB, FETCH; pcwrite=1 in JAL.
